rr_bus_arbiter: RTL

//  Round-robin arbiter that shares one MUX2-tree datapath/bus between N_REQ requesters.

---
 rtl/d2_arb_pkg.sv | 25 ++
 rtl/rr_priority_pick.sv | 44 ++++
 rtl/rr_bus_arbiter.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/d2_arb_pkg.sv
// d2_arb_pkg: shared definitions for the round-robin bus arbiter.
//   - FSM state encodings (2'd3 is unused and recovers to IDLE)
//   - default parameter values for the arbiter
//   - wrap_inc: modulo-n increment used for the rotating priority pointer
package d2_arb_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_OWN  = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    localparam int DEF_N_REQ    = 4;
    localparam int DEF_MAX_HOLD = 16;
    localparam int DEF_CNT_W    = 5;
    localparam int DEF_GAP      = 1;

    // Next index after idx, wrapping n-1 back to 0.
    function automatic int wrap_inc(input int idx, input int n);
        if (idx + 1 >= n) begin
            return 0;
        end else begin
            return idx + 1;
        end
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// rr_priority_pick: combinational rotating-priority picker.
//   elig_i  in   N_REQ  eligible requesters
//   ptr_i   in   IDX_W  index with highest priority this cycle
//   pick_o  out  IDX_W  first eligible index scanning ptr, ptr+1, ... mod N_REQ
//   any_o   out  1      at least one requester is eligible
// Rotates the eligible vector so ptr lands on bit 0, finds the lowest set
// bit, then adds ptr back (mod N_REQ) to recover the absolute index.
module rr_priority_pick
    import d2_arb_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    parameter int IDX_W = $clog2(DEF_N_REQ)
) (
    input  logic [N_REQ-1:0] elig_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [IDX_W-1:0] pick_o,
    output logic             any_o
);

    logic [2*N_REQ-1:0] dbl_s;
    logic [N_REQ-1:0]   rot_s;
    int                 off_s;
    int                 sum_s;

    // Doubling the vector lets a plain right shift act as a rotate.
    assign dbl_s = {elig_i, elig_i};
    assign rot_s = N_REQ'(dbl_s >> ptr_i);
    assign any_o = |rot_s;

    // First-one detect on the rotated vector: scanning downward leaves the lowest hit.
    always_comb begin
        off_s = 0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            off_s = rot_s[i] ? i : off_s;
        end
    end

    // Un-rotate: absolute index = (ptr + offset) mod N_REQ.
    always_comb begin
        sum_s  = 32'(ptr_i) + off_s;
        pick_o = (sum_s >= N_REQ) ? IDX_W'(sum_s - N_REQ) : IDX_W'(sum_s);
    end

endmodule

// File: rtl/rr_bus_arbiter.sv
// rr_bus_arbiter: round-robin owner selection for one shared mux-tree bus.
//   clk_i      in   1      clock, all state on posedge
//   rst_i      in   1      synchronous reset, active-high
//   req_i      in   N_REQ  per-requester request, held for the whole ownership
//   gnt_o      out  N_REQ  registered one-hot grant, or all-zero
//   sel_o      out  IDX_W  owner index for the mux select, 0 when no grant
//   busy_o     out  1      high in OWN or GAP
//   timeout_o  out  1      one-cycle pulse on a forced release
//   towner_o   out  IDX_W  last force-released requester, held until the next timeout
// An owner keeps the bus at most MAX_HOLD cycles; every release is followed
// by GAP all-zero grant cycles. A force-released requester stays masked
// until it drops its request.
module rr_bus_arbiter
    import d2_arb_pkg::*;
#(
    parameter int N_REQ    = DEF_N_REQ,
    parameter int IDX_W    = $clog2(DEF_N_REQ),
    parameter int MAX_HOLD = DEF_MAX_HOLD,
    parameter int CNT_W    = DEF_CNT_W,
    parameter int GAP      = DEF_GAP
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [N_REQ-1:0] req_i,
    output logic [N_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0] sel_o,
    output logic             busy_o,
    output logic             timeout_o,
    output logic [IDX_W-1:0] towner_o
);

    localparam logic [1:0]       GAP_LOAD = (GAP > 0) ? 2'(GAP - 1) : 2'd0;
    localparam logic [N_REQ-1:0] ONE_HOT0 = N_REQ'(1);

    logic [1:0]       state_q,   state_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic [1:0]       gap_q,     gap_d;
    logic [IDX_W-1:0] ptr_q,     ptr_d;
    logic [N_REQ-1:0] mask_q,    mask_d;
    logic [N_REQ-1:0] gnt_q,     gnt_d;
    logic [IDX_W-1:0] sel_q,     sel_d;
    logic             busy_q,    busy_d;
    logic             timeout_q, timeout_d;
    logic [IDX_W-1:0] towner_q,  towner_d;

    logic [N_REQ-1:0] elig_s;
    logic [IDX_W-1:0] pick_s;
    logic             any_s;
    logic             owner_req_s;
    logic             hold_done_s;
    logic             grant_s;
    logic             release_s;
    logic             force_s;

    assign elig_s = req_i & ~mask_q;

    rr_priority_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .elig_i (elig_s),
        .ptr_i  (ptr_q),
        .pick_o (pick_s),
        .any_o  (any_s)
    );

    assign owner_req_s = req_i[sel_q];
    assign hold_done_s = (cnt_q == CNT_W'(MAX_HOLD));
    // The last gap cycle arbitrates directly so exactly GAP zero cycles separate owners.
    assign grant_s     = any_s && ((state_q == ST_IDLE) ||
                                   ((state_q == ST_GAP) && (gap_q == 2'd0)));
    assign release_s   = (state_q == ST_OWN) && (!owner_req_s || hold_done_s);
    assign force_s     = (state_q == ST_OWN) && owner_req_s && hold_done_s;

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            gap_q     <= 2'd0;
            ptr_q     <= '0;
            mask_q    <= '0;
            gnt_q     <= '0;
            sel_q     <= '0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
            towner_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            gap_q     <= gap_d;
            ptr_q     <= ptr_d;
            mask_q    <= mask_d;
            gnt_q     <= gnt_d;
            sel_q     <= sel_d;
            busy_q    <= busy_d;
            timeout_q <= timeout_d;
            towner_q  <= towner_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: state_d = any_s ? ST_OWN : ST_IDLE;
            ST_OWN: begin
                if (release_s) begin
                    state_d = (GAP > 0) ? ST_GAP : ST_IDLE;
                end else begin
                    state_d = ST_OWN;
                end
            end
            ST_GAP: begin
                if (gap_q != 2'd0) begin
                    state_d = ST_GAP;
                end else begin
                    state_d = any_s ? ST_OWN : ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Counters, pointer, mask and next values of the registered outputs.
    always_comb begin
        mask_d    = mask_q & req_i;
        timeout_d = 1'b0;
        towner_d  = towner_q;

        if (grant_s) begin
            cnt_d = CNT_W'(1);
        end else if ((state_q == ST_OWN) && !release_s) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end

        if (release_s) begin
            ptr_d = IDX_W'(wrap_inc(32'(sel_q), N_REQ));
            gap_d = GAP_LOAD;
        end else if ((state_q == ST_GAP) && (gap_q != 2'd0)) begin
            ptr_d = ptr_q;
            gap_d = gap_q - 2'd1;
        end else begin
            ptr_d = ptr_q;
            gap_d = gap_q;
        end

        // Masking the timed-out owner keeps it from winning again until it drops Req.
        if (force_s) begin
            timeout_d      = 1'b1;
            towner_d       = sel_q;
            mask_d[sel_q]  = 1'b1;
        end else begin
            timeout_d      = 1'b0;
        end

        // Grant/select are forced to zero whenever the next state is not OWN.
        if (grant_s) begin
            gnt_d = ONE_HOT0 << pick_s;
            sel_d = pick_s;
        end else if (state_d == ST_OWN) begin
            gnt_d = gnt_q;
            sel_d = sel_q;
        end else begin
            gnt_d = '0;
            sel_d = '0;
        end

        busy_d = (state_d != ST_IDLE);
    end

    assign gnt_o     = gnt_q;
    assign sel_o     = sel_q;
    assign busy_o    = busy_q;
    assign timeout_o = timeout_q;
    assign towner_o  = towner_q;

endmodule
